// File: rtl/bcd_converter.sv
// bcd_converter: 16-bit unsigned binary to 5-digit BCD using a sequential
// double-dabble engine. Values strobed in while a conversion is in flight
// wait in a 1-entry pending buffer (newest wins); every value that gets
// overwritten is counted in a saturating drop counter.
// Optional feature: define BCD_CONVERTER_BLANK_EN to build the per-digit
// leading-zero blank mask; when it is undefined, blank is tied to zero.
// Timing: a value accepted at edge N produces bcd_valid in the cycle after
// edge N+17 (16 CONV iterations, one DONE cycle, registered outputs).
module bcd_converter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic [19:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [4:0]  blank,
    output logic [7:0]  drop_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [3:0]  iter_q,      iter_d;
    logic [15:0] shift_q,     shift_d;
    logic [19:0] scratch_q,   scratch_d;
    logic [19:0] bcd_q,       bcd_d;
    logic        bcd_valid_q, bcd_valid_d;
    logic [7:0]  drop_cnt_q,  drop_cnt_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic        pend_full_q, pend_full_d;

    logic [19:0] scratch_adj;
    logic        drop_evt;

    // Double-dabble correction: add 3 to every scratch digit that is 5 or more.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic: FSM sequencing, conversion datapath, pending buffer, drops.
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        pend_data_d = pend_data_q;
        pend_full_d = pend_full_q;
        drop_cnt_d  = drop_cnt_q;
        drop_evt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = in_data;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = CONV;
                end
            end

            CONV: begin
                // Shift {scratch, shift register} left by one after correction.
                // The top scratch bit is always zero for a 16-bit input.
                {scratch_d, shift_d} = {scratch_adj[18:0], shift_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = DONE;
                end
                if (in_valid) begin
                    drop_evt    = pend_full_q;
                    pend_data_d = in_data;
                    pend_full_d = 1'b1;
                end
            end

            DONE: begin
                bcd_d       = scratch_q;
                bcd_valid_d = 1'b1;
                iter_d      = '0;
                scratch_d   = '0;
                if (in_valid) begin
                    // A fresh strobe beats the buffered value, which is then lost.
                    shift_d     = in_data;
                    drop_evt    = pend_full_q;
                    pend_full_d = 1'b0;
                    state_d     = CONV;
                end else if (pend_full_q) begin
                    shift_d     = pend_data_q;
                    pend_full_d = 1'b0;
                    state_d     = CONV;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (drop_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Control and output registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments; always_comb above uses blocking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            drop_cnt_q  <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            drop_cnt_q  <= drop_cnt_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Datapath registers: always loaded before being read, so no reset needed.
    // NOTE: leaving pure data registers unreset is deliberate; their qualifiers are reset.
    always_ff @(posedge clk) begin
        shift_q     <= shift_d;
        scratch_q   <= scratch_d;
        pend_data_q <= pend_data_d;
    end

`ifdef BCD_CONVERTER_BLANK_EN
    logic [4:0] blank_q, blank_d;
    logic [4:0] blank_calc;
    logic       upper_zero;

    // Leading-zero mask: digit i>0 blanks when it and all higher digits are zero.
    always_comb begin
        blank_calc = '0;
        upper_zero = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            upper_zero    = upper_zero & (scratch_q[4*i +: 4] == 4'd0);
            blank_calc[i] = upper_zero;
        end
        blank_d = (state_q == DONE) ? blank_calc : blank_q;
    end

    // Blank mask register, updated together with bcd.
    always_ff @(posedge clk) begin
        if (!rst) begin
            blank_q <= 5'b11110;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 5'b00000;
`endif

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = (state_q == CONV) || (state_q == DONE);
    assign drop_cnt  = drop_cnt_q;

endmodule
